// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the CPU multiply/divide unit.
// Holds the operand width default, the op_i encodings and the
// mul_div_unit FSM state encoding.
package cpu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // op_i encodings: bit 1 selects divide, bit 0 selects unsigned
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative HI/LO multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle, WIDTH iterations per operation, with sign fix-up
// applied as the result is written into HI/LO.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-low reset
//   start_i    begin operation op_i (accepted in IDLE only)
//   op_i       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data_i  operand A (multiplicand / dividend, also move data)
//   rt_data_i  operand B (multiplier / divisor)
//   mthi_i     write rs_data_i into HI (IDLE/DONE only)
//   mtlo_i     write rs_data_i into LO (IDLE/DONE only)
//   hi_o/lo_o  HI/LO registers
//   busy_o     high while iterating
//   done_o     one-cycle pulse when HI/LO hold a new result
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  logic [1:0]         state_reg;
  logic [5:0]         count_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic [WIDTH-1:0]   a_reg;        // raw operand A, needed for divide-by-zero
  logic [WIDTH-1:0]   b_mag_reg;    // |B|: addend for multiply, divisor for divide
  logic [2*WIDTH-1:0] acc_reg;      // {partial product | remainder, multiplier | quotient}
  logic               neg_res_reg;  // operand signs differ on a signed op
  logic               neg_rem_reg;  // dividend negative on a signed op
  logic               div_zero_reg;

  // Operand magnitudes at start
  logic             signed_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign signed_op = ~op_i[0];
  assign a_mag = (signed_op && rs_data_i[WIDTH-1]) ? -rs_data_i : rs_data_i;
  assign b_mag = (signed_op && rt_data_i[WIDTH-1]) ? -rt_data_i : rt_data_i;

  // Multiply step: add B into the upper half when the current multiplier
  // bit (acc LSB) is set, then shift the whole accumulator right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                    (acc_reg[0] ? {1'b0, b_mag_reg} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder,
  // subtract the divisor if it fits, shift the quotient bit in at the bottom.
  logic [WIDTH:0]     rem_shift, div_diff;
  logic               div_fits;
  logic [WIDTH-1:0]   new_rem;
  logic [2*WIDTH-1:0] div_next;
  assign rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_diff  = rem_shift - {1'b0, b_mag_reg};
  assign div_fits  = (rem_shift >= {1'b0, b_mag_reg});
  assign new_rem   = div_fits ? div_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign div_next  = {new_rem, acc_reg[WIDTH-2:0], div_fits};

  logic [2*WIDTH-1:0] step_next;
  assign step_next = (state_reg == ST_DIV) ? div_next : mul_next;

  // Final result, valid on the last iteration cycle
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;
  assign mul_prod = neg_res_reg ? -step_next : step_next;
  assign quot     = neg_res_reg ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
  assign rem      = neg_rem_reg ? -step_next[2*WIDTH-1:WIDTH]
                                :  step_next[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi = mul_prod[2*WIDTH-1:WIDTH];
    res_lo = mul_prod[WIDTH-1:0];
    if (state_reg == ST_DIV) begin
      // Divide by zero leaves A in HI unmodified and all ones in LO
      res_hi = div_zero_reg ? a_reg : rem;
      res_lo = div_zero_reg ? {WIDTH{1'b1}} : quot;
    end
  end

  logic last_iter, iterating, move_ok;
  assign iterating = (state_reg == ST_MUL) || (state_reg == ST_DIV);
  assign last_iter = iterating && (count_reg == 6'(WIDTH - 1));
  assign move_ok   = (state_reg == ST_IDLE) || (state_reg == ST_DONE);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      a_reg        <= '0;
      b_mag_reg    <= '0;
      acc_reg      <= '0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg    <= op_i[1] ? ST_DIV : ST_MUL;
            count_reg    <= '0;
            a_reg        <= rs_data_i;
            b_mag_reg    <= b_mag;
            acc_reg      <= {{WIDTH{1'b0}}, a_mag};
            neg_res_reg  <= signed_op && (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
            neg_rem_reg  <= signed_op && rs_data_i[WIDTH-1];
            div_zero_reg <= (rt_data_i == '0);
          end
        end
        ST_MUL, ST_DIV: begin
          acc_reg   <= step_next;
          count_reg <= count_reg + 6'd1;
          if (last_iter) begin
            state_reg <= ST_DONE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase

      // Moves and result write-back occur in disjoint states
      if (move_ok && mthi_i) begin
        hi_reg <= rs_data_i;
      end
      if (move_ok && mtlo_i) begin
        lo_reg <= rs_data_i;
      end
      if (last_iter) begin
        hi_reg <= res_hi;
        lo_reg <= res_lo;
      end
    end
  end

  assign hi_o   = hi_reg;
  assign lo_o   = lo_reg;
  assign busy_o = iterating;
  assign done_o = (state_reg == ST_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit -- directed self-checking bench for mul_div_unit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .op_i      (op),
    .rs_data_i (rs_data),
    .rt_data_i (rt_data),
    .mthi_i    (mthi),
    .mtlo_i    (mtlo),
    .hi_o      (hi),
    .lo_o      (lo),
    .busy_o    (busy),
    .done_o    (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation (also releases reset), optionally with a coincident
  // mthi move, and check busy, done latency, HI/LO and the return to idle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic mv,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    bit seen;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = o; rs_data = a; rt_data = b; mthi = mv;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    if (mv) chk({tag, " move hi"}, hi, a);
    cyc = 1;
    seen = 0;
    while (!seen && cyc < 100) begin
      if (done) seen = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, " latency"}, 32'(cyc), 32'd33);
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " lo"}, lo, elo);
    @(negedge clk);
    chk({tag, " done end"}, 32'(done), 32'd0);
    chk({tag, " busy end"}, 32'(busy), 32'd0);
    $display("op %s a=%h b=%h -> hi=%h lo=%h cycles=%0d", tag, a, b, hi, lo, cyc);
  endtask

  initial begin
    int dones;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    $display("reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);

    run_op("MULT -3*5",      2'b00, 32'hFFFFFFFD, 32'd5,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("MULTU max*max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    run_op("MULTU 0x12345678*16", 2'b01, 32'h12345678, 32'h10,  1'b0, 32'h00000001, 32'h23456780);
    run_op("MULT 7*-6",      2'b00, 32'd7,        32'hFFFFFFFA, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFD6);
    run_op("DIV -7/2",       2'b10, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("DIVU 100/7",     2'b11, 32'd100,      32'd7,        1'b0, 32'd2,        32'd14);
    run_op("DIVU 7/0",       2'b11, 32'd7,        32'd0,        1'b0, 32'd7,        32'hFFFFFFFF);
    run_op("DIV -256/0",     2'b10, 32'hFFFFFF00, 32'd0,        1'b0, 32'hFFFFFF00, 32'hFFFFFFFF);
    run_op("DIV min/-1",     2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000);

    // HI/LO hold while idle
    repeat (5) @(negedge clk);
    chk("hold hi", hi, 32'h00000000);
    chk("hold lo", lo, 32'h80000000);
    $display("hold: hi=%h lo=%h", hi, lo);

    // mthi in IDLE: HI written, LO unchanged, no done pulse
    rs_data = 32'hCAFEF00D; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi hi", hi, 32'hCAFEF00D);
    chk("mthi lo", lo, 32'h80000000);
    chk("mthi done", 32'(done), 32'd0);
    $display("mthi: hi=%h lo=%h done=%b", hi, lo, done);

    // mtlo in IDLE
    rs_data = 32'h000055AA; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo lo", lo, 32'h000055AA);
    chk("mtlo hi", hi, 32'hCAFEF00D);
    $display("mtlo: hi=%h lo=%h", hi, lo);

    // Start and move mid-operation are ignored; reset abandons the operation
    start = 1'b1; op = 2'b00; rs_data = 32'd3; rt_data = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b11; mthi = 1'b1; rs_data = 32'h1234;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("midop hi", hi, 32'hCAFEF00D);
    chk("midop busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort hi", hi, 32'h0);
    chk("abort lo", lo, 32'h0);
    chk("abort done", 32'(done), 32'd0);
    $display("abort: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
    rst = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort no done", 32'(dones), 32'd0);
    $display("abort: done pulses after reset=%0d", dones);

    // Reset then start on the first edge with reset released, with a
    // coincident mthi that the result later overwrites
    rst = 1'b0;
    @(negedge clk);
    run_op("MULTU 2*3 mthi", 2'b01, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);

    // Start while in DONE is ignored
    start = 1'b1; op = 2'b11; rs_data = 32'd10; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    dones = 1;
    while (!done && dones < 100) begin
      @(negedge clk);
      dones++;
    end
    chk("DIVU 10/3 latency", 32'(dones), 32'd33);
    chk("DIVU 10/3 hi", hi, 32'd1);
    chk("DIVU 10/3 lo", lo, 32'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start in done busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("start in done idle", 32'(busy), 32'd0);
    $display("start in DONE: busy=%b hi=%h lo=%h", busy, hi, lo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
